// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_pkg: shared Set-2 constants, decoder states, event layout and digit map.
package ps2_pkg;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] FAKE_SHIFT = 8'h12;
  localparam logic [2:0] PAUSE_LEN = 3'd7;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_EXT = 3'd1;
  localparam state_t S_BRK = 3'd2;
  localparam state_t S_EXT_BRK = 3'd3;
  localparam state_t S_SKIP = 3'd4;
  typedef struct packed {
    logic [7:0] code;
    logic brk;
    logic ext;
    logic dvalid;
    logic [3:0] digit;
  } evt_t;
  function automatic logic is_ctrl(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction
  // Returns {is_digit, value}; main row and keypad both map to 0-9.
  function automatic logic [4:0] digit_of(input logic [7:0] c);
    case (c)
      8'h45, 8'h70: return 5'h10;
      8'h16, 8'h69: return 5'h11;
      8'h1E, 8'h72: return 5'h12;
      8'h26, 8'h7A: return 5'h13;
      8'h25, 8'h6B: return 5'h14;
      8'h2E, 8'h73: return 5'h15;
      8'h36, 8'h74: return 5'h16;
      8'h3D, 8'h6C: return 5'h17;
      8'h3E, 8'h75: return 5'h18;
      8'h46, 8'h7D: return 5'h19;
      default: return 5'h00;
    endcase
  endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte input and key-event handshake of the scan-code decoder.
interface ps2_scancode_decoder_if;
  logic CODE_VALID;
  logic [7:0] CODEWORD;
  logic EVT_READY;
  logic EVT_VALID;
  logic [7:0] EVT_CODE;
  logic EVT_BREAK;
  logic EVT_EXT;
  logic EVT_DIGIT_VALID;
  logic [3:0] EVT_DIGIT;
  logic OVERFLOW;
  logic [7:0] LED;
  modport master(input CODE_VALID, CODEWORD, EVT_READY,
                 output EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, EVT_DIGIT_VALID, EVT_DIGIT, OVERFLOW, LED);
  modport slave(output CODE_VALID, CODEWORD, EVT_READY,
                input EVT_VALID, EVT_CODE, EVT_BREAK, EVT_EXT, EVT_DIGIT_VALID, EVT_DIGIT, OVERFLOW, LED);
endinterface

// File: rtl/ps2_scancode_decoder_event_fifo.sv
// event_fifo: synchronous FIFO with wrap-bit pointers; a full FIFO accepts a push only alongside a pop.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_pop, do_push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      mem <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds Set-2 prefix sequences into buffered key events with repeat filter and digit map.
module ps2_scancode_decoder import ps2_pkg::*; #(
  parameter int DEPTH = 4,
  parameter bit FILTER_REPEAT = 1
) (
  input logic CLK,
  input logic RST,
  ps2_scancode_decoder_if.master bus
);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [8:0] held, held_n;
  logic [7:0] b, led;
  logic [4:0] dg;
  logic emit_raw, brk, ext, match, emit, acc, full, empty, ovf;
  evt_t ev, head;
  assign b = bus.CODEWORD;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    emit_raw = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (bus.CODE_VALID)
      case (state)
        S_IDLE: begin
          state_n = b == PFX_EXT ? S_EXT : b == PFX_BRK ? S_BRK : b == PFX_PAUSE ? S_SKIP : S_IDLE;
          cnt_n = b == PFX_PAUSE ? PAUSE_LEN : cnt;
          emit_raw = !(b inside {PFX_EXT, PFX_BRK, PFX_PAUSE}) && !is_ctrl(b);
        end
        S_EXT: begin
          state_n = b == PFX_BRK ? S_EXT_BRK : S_IDLE;
          emit_raw = b != PFX_BRK && b != FAKE_SHIFT;
          ext = 1'b1;
        end
        S_BRK: begin
          state_n = S_IDLE;
          emit_raw = 1'b1;
          brk = 1'b1;
        end
        S_EXT_BRK: begin
          state_n = S_IDLE;
          emit_raw = b != FAKE_SHIFT;
          brk = 1'b1;
          ext = 1'b1;
        end
        S_SKIP: begin
          cnt_n = cnt - 3'd1;
          state_n = cnt == 3'd1 ? S_IDLE : S_SKIP;
        end
        default: state_n = S_IDLE;
      endcase
  end
  // held == 0 means no key held; {0,00} can never be a make since 00 is dropped in IDLE.
  assign match = {ext, b} == held;
  assign emit = emit_raw && !(FILTER_REPEAT && !brk && match);
  assign held_n = (!FILTER_REPEAT || !emit) ? held : !brk ? {ext, b} : match ? 9'd0 : held;
  assign dg = ext ? 5'd0 : digit_of(b);
  assign ev = {b, brk, ext, dg};
  assign acc = emit && (!full || bus.EVT_READY);
  event_fifo #(.DEPTH(DEPTH), .W($bits(evt_t))) u_fifo (
    .clk(CLK), .rst(RST), .push(emit), .din(ev), .pop(bus.EVT_READY),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= S_IDLE;
      cnt <= '0;
      held <= '0;
      led <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      held <= held_n;
      if (acc && !brk) led <= b;
      if (emit && full && !bus.EVT_READY) ovf <= 1'b1;
    end
  assign bus.EVT_VALID = !empty;
  assign bus.EVT_CODE = head.code;
  assign bus.EVT_BREAK = head.brk;
  assign bus.EVT_EXT = head.ext;
  assign bus.EVT_DIGIT_VALID = head.dvalid;
  assign bus.EVT_DIGIT = head.digit;
  assign bus.OVERFLOW = ovf;
  assign bus.LED = led;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed scan-code sequences with hand-computed key events.
module tb_ps2_scancode_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  ps2_scancode_decoder_if bus();
  ps2_scancode_decoder #(.DEPTH(4), .FILTER_REPEAT(1)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] c);
    bus.CODE_VALID = 1'b1;
    bus.CODEWORD = c;
    @(negedge clk);
    bus.CODE_VALID = 1'b0;
    @(negedge clk);
  endtask
  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask
  task automatic expect_evt(input string tag, input logic [7:0] code, input logic b, input logic e,
                            input logic dv, input logic [3:0] d);
    check({tag, ".valid"}, bus.EVT_VALID, 1);
    check({tag, ".code"}, bus.EVT_CODE, code);
    check({tag, ".brk"}, bus.EVT_BREAK, b);
    check({tag, ".ext"}, bus.EVT_EXT, e);
    check({tag, ".dv"}, bus.EVT_DIGIT_VALID, dv);
    check({tag, ".digit"}, bus.EVT_DIGIT, d);
    bus.EVT_READY = 1'b1;
    @(negedge clk);
    bus.EVT_READY = 1'b0;
  endtask
  initial begin
    logic [7:0] mk[6];
    mk = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33};
    bus.CODE_VALID = 1'b0;
    bus.CODEWORD = 8'h00;
    bus.EVT_READY = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst.valid", bus.EVT_VALID, 0);
    check("rst.led", bus.LED, 0);
    check("rst.ovf", bus.OVERFLOW, 0);
    check("rst.code", bus.EVT_CODE, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h16);
    check("make16.led", bus.LED, 8'h16);
    expect_evt("make16", 8'h16, 0, 0, 1, 1);
    send_seq('{8'hF0, 8'h16});
    expect_evt("brk16", 8'h16, 1, 0, 1, 1);
    check("brk16.empty", bus.EVT_VALID, 0);
    check("brk16.led", bus.LED, 8'h16);
    send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    check("ext75.led", bus.LED, 8'h75);
    expect_evt("ext75m", 8'h75, 0, 1, 0, 0);
    expect_evt("ext75b", 8'h75, 1, 1, 0, 0);
    send_seq('{8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12, 8'hFA, 8'hAA});
    check("fake_shift.empty", bus.EVT_VALID, 0);
    send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
    check("pause.empty", bus.EVT_VALID, 0);
    send(8'h45);
    expect_evt("after_pause", 8'h45, 0, 0, 1, 0);
    check("after_pause.empty", bus.EVT_VALID, 0);
    send_seq('{8'h1E, 8'h1E, 8'h1E, 8'hF0, 8'h1E});
    expect_evt("rep_make", 8'h1E, 0, 0, 1, 2);
    expect_evt("rep_brk", 8'h1E, 1, 0, 1, 2);
    check("rep.empty", bus.EVT_VALID, 0);
    for (int i = 0; i < 4; i++) send(mk[i]);
    check("full4.ovf", bus.OVERFLOW, 0);
    send(mk[4]);
    send(mk[5]);
    check("ovf.set", bus.OVERFLOW, 1);
    check("ovf.led", bus.LED, 8'h2B);
    for (int i = 0; i < 4; i++) expect_evt($sformatf("drain%0d", i), mk[i], 0, 0, 0, 0);
    check("drain.empty", bus.EVT_VALID, 0);
    check("ovf.sticky", bus.OVERFLOW, 1);
    send_seq('{8'h15, 8'h1D, 8'h24, 8'h2D});
    bus.EVT_READY = 1'b1;
    bus.CODE_VALID = 1'b1;
    bus.CODEWORD = 8'h2C;
    @(negedge clk);
    bus.EVT_READY = 1'b0;
    bus.CODE_VALID = 1'b0;
    @(negedge clk);
    check("fullpop.led", bus.LED, 8'h2C);
    expect_evt("fullpop0", 8'h1D, 0, 0, 0, 0);
    expect_evt("fullpop1", 8'h24, 0, 0, 0, 0);
    expect_evt("fullpop2", 8'h2D, 0, 0, 0, 0);
    expect_evt("fullpop3", 8'h2C, 0, 0, 0, 0);
    check("fullpop.empty", bus.EVT_VALID, 0);
    send(8'h16);
    send(8'hE0);
    rst = 1'b1;
    #1;
    check("midrst.valid", bus.EVT_VALID, 0);
    check("midrst.led", bus.LED, 0);
    check("midrst.ovf", bus.OVERFLOW, 0);
    check("midrst.code", bus.EVT_CODE, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h70);
    expect_evt("post_rst", 8'h70, 0, 0, 1, 0);
    check("post_rst.empty", bus.EVT_VALID, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
